// File: rtl/game_flow_ctrl.sv
// Game-flow controller: INIT/WAIT/PLAY/LOST/WON sequencing, ball slots, life bar,
// stage progression, block-map command arbitration and cleared-map detection.
// Optional PAUSE state is compiled in when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int BALL_NUM  = 2,
    parameter int STAGE_NUM = 4,
    parameter int LIFE_NUM  = 6,
    parameter int ROWS      = 30,
    parameter int COLS      = 10,
    localparam int SBIT = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1,
    localparam int RBIT = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CBIT = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic                stage_ovr,
    input  logic [SBIT-1:0]     stage_sel,
    input  logic                bm_ready,
    input  logic [3:0]          bm_block,
    input  logic [BALL_NUM-1:0] ball_lost,
    input  logic [BALL_NUM-1:0] ball_hit,
    input  logic                give_ball,
    input  logic                drop_block,
    input  logic                btn_l,
    input  logic                btn_r,
    output logic [BALL_NUM-1:0] b_active,
    output logic                run,
    output logic                launch,
    output logic                bm_enable,
    output logic [1:0]          bm_func,
    output logic [RBIT-1:0]     bm_row,
    output logic [CBIT-1:0]     bm_col,
    output logic [SBIT-1:0]     bm_stage,
    output logic [SBIT-1:0]     stage,
    output logic [LIFE_NUM-1:0] hp,
    output logic                init,
    output logic                dead,
    output logic                win
);

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_PLAY,
`ifdef GAME_PAUSE_EN
        S_PAUSE,
`endif
        S_LOST,
        S_WON
    } state_t;

    localparam logic [SBIT-1:0] LAST_STAGE = SBIT'(STAGE_NUM - 1);

    state_t                r_state;
    state_t                w_next;
    logic [SBIT-1:0]       r_stage;
    logic [LIFE_NUM-1:0]   r_hp;
    logic [BALL_NUM-1:0]   r_active;
    logic [RBIT-1:0]       r_row;
    logic [CBIT-1:0]       r_col;
    logic                  r_flag;
    logic                  r_launch;

    logic                  w_go;
    logic                  w_brk;
    logic                  w_first_cell;
    logic                  w_last_cell;
    logic                  w_empty;
    logic                  w_paused;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_lose_life;
    logic                  w_enter_wait;
    logic [SBIT-1:0]       w_new_stage;

    assign w_go         = start & bm_ready;
    assign w_brk        = (bm_block != 4'd0) && (bm_block != 4'd1) && (bm_block != 4'd7);
    assign w_first_cell = (r_row == '0) && (r_col == '0);
    assign w_last_cell  = (r_row == RBIT'(ROWS - 1)) && (r_col == CBIT'(COLS - 1));
    assign w_empty      = w_last_cell && r_flag && !w_brk;

`ifdef GAME_PAUSE_EN
    assign w_paused = (r_state == S_PAUSE);
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_paused       = 1'b0;
`endif

    assign w_load      = ((r_state == S_INIT) && w_go) ||
                         ((r_state == S_PLAY) && w_empty && (r_stage != LAST_STAGE));
    assign w_clear     = (r_state == S_PLAY) && (|ball_hit) && bm_ready;
    assign w_new_stage = stage_ovr ? stage_sel :
                         (r_state == S_INIT) ? '0 : r_stage + SBIT'(1);
    // Stage clear outranks ball loss, so the life is only taken when the map is not empty.
    assign w_lose_life  = (r_state == S_PLAY) && !w_empty && (r_active == '0) && r_hp[1];
    assign w_enter_wait = (w_next == S_WAIT) && (r_state != S_WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: if (w_go) w_next = S_WAIT;
            S_WAIT: if (w_go) w_next = S_PLAY;
            S_PLAY: begin
                if (w_empty)                w_next = (r_stage == LAST_STAGE) ? S_WON : S_WAIT;
                else if (r_active == '0)    w_next = r_hp[1] ? S_WAIT : S_LOST;
`ifdef GAME_PAUSE_EN
                else if (pause)             w_next = S_PAUSE;
`endif
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: if (pause) w_next = S_PLAY;
`endif
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        bm_enable = 1'b1;
        bm_func   = 2'b00;
        if (w_load)                        bm_func = 2'b00;
        else if (w_clear)                  bm_func = 2'b01;
        else if (drop_block && !w_paused)  bm_func = 2'b11;
        else if (btn_l)                    bm_func = 2'b10;
        else if (btn_r)                    bm_func = 2'b11;
        else                               bm_enable = 1'b0;
        run  = (r_state == S_PLAY);
        init = (r_state == S_INIT);
        dead = (r_state == S_LOST);
        win  = (r_state == S_WON);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stage  <= '0;
            r_hp     <= '1;
            r_active <= '0;
            r_launch <= 1'b0;
        end else begin
            r_launch <= (r_state == S_WAIT) && w_go;
            if (w_load)      r_stage <= w_new_stage;
            if (w_lose_life) r_hp    <= r_hp >> 1;
            if (w_enter_wait)                 r_active <= BALL_NUM'(1);
            else if (give_ball && !w_paused)  r_active <= '1;
            else if (r_state == S_PLAY)       r_active <= r_active & ~ball_lost;
        end
    end

    // The empty flag survives a frame only if every cell was valid, unbreakable and command-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_flag <= 1'b0;
        end else begin
            if (r_col == CBIT'(COLS - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RBIT'(ROWS - 1)) ? '0 : r_row + RBIT'(1);
            end else begin
                r_col <= r_col + CBIT'(1);
            end
            if (w_first_cell)                        r_flag <= bm_ready && !w_brk && !bm_enable;
            else if (w_brk || !bm_ready || bm_enable) r_flag <= 1'b0;
        end
    end

    assign b_active = r_active;
    assign launch   = r_launch;
    assign bm_row   = r_row;
    assign bm_col   = r_col;
    assign bm_stage = w_new_stage;
    assign stage    = r_stage;
    assign hp       = r_hp;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random games checked cycle by cycle
// against a rule-level model of the game flow and a simple block-map responder.
module tb_game_flow_ctrl;

    localparam int BALL_NUM  = 2;
    localparam int STAGE_NUM = 4;
    localparam int LIFE_NUM  = 6;
    localparam int ROWS      = 30;
    localparam int COLS      = 10;
    localparam int CELLS     = ROWS * COLS;

    localparam int M_INIT = 0, M_WAIT = 1, M_PLAY = 2, M_PAUSE = 3, M_LOST = 4, M_WON = 5;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, start, pause, stage_ovr, bm_ready, give_ball, drop_block, btn_l, btn_r;
    logic [1:0] stage_sel;
    logic [3:0] bm_block;
    logic [BALL_NUM-1:0] ball_lost, ball_hit, b_active;
    logic run, launch, bm_enable, init, dead, win;
    logic [1:0] bm_func, bm_stage, stage;
    logic [4:0] bm_row;
    logic [3:0] bm_col;
    logic [LIFE_NUM-1:0] hp;

    always #5 clock = ~clock;

    game_flow_ctrl #(.BALL_NUM(BALL_NUM), .STAGE_NUM(STAGE_NUM), .LIFE_NUM(LIFE_NUM),
                     .ROWS(ROWS), .COLS(COLS)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .stage_ovr(stage_ovr), .stage_sel(stage_sel), .bm_ready(bm_ready), .bm_block(bm_block),
        .ball_lost(ball_lost), .ball_hit(ball_hit), .give_ball(give_ball), .drop_block(drop_block),
        .btn_l(btn_l), .btn_r(btn_r), .b_active(b_active), .run(run), .launch(launch),
        .bm_enable(bm_enable), .bm_func(bm_func), .bm_row(bm_row), .bm_col(bm_col),
        .bm_stage(bm_stage), .stage(stage), .hp(hp), .init(init), .dead(dead), .win(win)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model: game phase, stage number, remaining lives, live ball mask, scan position
    int         m_st, m_stage, m_lives, m_t, m_good;
    logic [1:0] m_balls;
    logic       m_launch;
    logic [3:0] m_map [CELLS];
    bit         m_blank;
    logic       obs_en;
    logic [1:0] obs_func, obs_stage;

    function automatic logic is_brk(input logic [3:0] k);
        return (k != 4'd0) && (k != 4'd1) && (k != 4'd7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_map(input int s);
        for (int i = 0; i < CELLS; i++) m_map[i] = 4'd0;
        if (!m_blank) begin
            for (int k = 0; k < 2; k++) m_map[$urandom_range(CELLS-1)] = ($urandom_range(1) == 1) ? 4'd1 : 4'd7;
            for (int k = 0; k <= s; k++) m_map[$urandom_range(CELLS-1)] = 4'($urandom_range(6, 2) + (($urandom_range(1) == 1) ? 6 : 0));
        end
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; stage_ovr = 0; stage_sel = 0; bm_ready = 1;
        give_ball = 0; drop_block = 0; btn_l = 0; btn_r = 0; ball_lost = 0; ball_hit = 0;
    endtask

    task automatic check_regs();
        check("stage", stage, m_stage);
        check("hp", hp, (1 << m_lives) - 1);
        check("b_active", b_active, m_balls);
        check("run", run, m_st == M_PLAY);
        check("launch", launch, m_launch);
        check("init", init, m_st == M_INIT);
        check("dead", dead, m_st == M_LOST);
        check("win", win, m_st == M_WON);
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1;
        m_st = M_INIT; m_stage = 0; m_lives = LIFE_NUM; m_balls = 0; m_launch = 0;
        m_t = 0; m_good = 0;
        check_regs();
        check("rst_row", bm_row, 0);
        check("rst_col", bm_col, 0);
        @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic tick();
        int c, st, nst, new_stage;
        logic brk, emp, go, ld, clr, en, ok;
        logic [1:0] fn;
        c  = m_t;
        st = m_st;
        bm_block = m_map[c];
        #1;
        brk = is_brk(m_map[c]);
        emp = (c == CELLS-1) && (m_good == CELLS-1) && !brk;
        go  = start && bm_ready;
        ld  = (st == M_INIT && go) || (st == M_PLAY && emp && m_stage != STAGE_NUM-1);
        new_stage = stage_ovr ? int'(stage_sel) : (st == M_INIT ? 0 : (m_stage + 1) % STAGE_NUM);
        clr = (st == M_PLAY) && (ball_hit != 0) && bm_ready;
        en = 1;
        if (ld)                               fn = 2'b00;
        else if (clr)                         fn = 2'b01;
        else if (drop_block && st != M_PAUSE) fn = 2'b11;
        else if (btn_l)                       fn = 2'b10;
        else if (btn_r)                       fn = 2'b11;
        else begin en = 0; fn = 2'b00; end
        obs_en = bm_enable; obs_func = bm_func; obs_stage = bm_stage;
        check("bm_enable", bm_enable, en);
        check("bm_func", bm_func, fn);
        if (ld) check("bm_stage", bm_stage, new_stage);
        check("bm_row", bm_row, c / COLS);
        check("bm_col", bm_col, c % COLS);
        @(posedge clock);
        #1;
        ok = bm_ready && !brk && !en;
        if (c == 0) m_good = ok ? 1 : 0;
        else if (ok && m_good == c) m_good = c + 1;
        m_launch = (st == M_WAIT) && go;
        nst = st;
        case (st)
            M_INIT:  if (go) nst = M_WAIT;
            M_WAIT:  if (go) nst = M_PLAY;
            M_PLAY: begin
                if (emp) nst = (m_stage == STAGE_NUM-1) ? M_WON : M_WAIT;
                else if (m_balls == 0) begin
                    if (m_lives == 1) nst = M_LOST;
                    else begin m_lives--; nst = M_WAIT; end
                end else if (pause && PAUSE_EN) nst = M_PAUSE;
            end
            M_PAUSE: if (pause) nst = M_PLAY;
            default: nst = st;
        endcase
        if (nst == M_WAIT && st != M_WAIT)   m_balls = 2'b01;
        else if (give_ball && st != M_PAUSE) m_balls = 2'b11;
        else if (st == M_PLAY)               m_balls = m_balls & ~ball_lost;
        if (ld) begin m_stage = new_stage; load_map(new_stage); end
        else if (clr) m_map[c] = 4'd0;
        m_st = nst;
        m_t  = (c + 1) % CELLS;
        check_regs();
        idle_inputs();
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 0; bm_block = 0; m_blank = 0;
        do_reset();

        // launch sequence
        start = 1; tick();
        check("d1_b_active", b_active, 2'b01);
        check("d1_load_func", {obs_en, obs_func}, 3'b100);
        start = 1; tick();
        check("d1_launch", launch, 1);
        check("d1_run", run, 1);
        tick();
        check("d1_launch_off", launch, 0);

        // burn every life
        for (int k = LIFE_NUM; k >= 1; k--) begin
            ball_lost = 2'b01; tick();
            check("d2_no_ball", b_active, 0);
            tick();
            if (k > 1) begin
                check("d2_hp", hp, (1 << (k - 1)) - 1);
                start = 1; tick();
            end else begin
                check("d2_dead", dead, 1);
            end
        end

        // override to stage 2 on an empty map
        do_reset();
        m_blank = 1;
        start = 1; stage_ovr = 1; stage_sel = 2; tick();
        check("d5_ovr_stage", obs_stage, 2);
        check("d5_stage", stage, 2);
        start = 1; tick();
        ball_hit = 2'b01; drop_block = 1; tick();
        check("d4_clear_only", obs_func, 2'b01);
        give_ball = 1; ball_lost = 2'b10; tick();
        check("d4_give_wins", b_active, 2'b11);

        // clear and ball loss land together
        n = 0;
        while (!(m_t == CELLS-2 && m_good == CELLS-2) && n < 2*CELLS + 10) begin tick(); n++; end
        check("d5_sync_bound", n < 2*CELLS + 10, 1);
        ball_lost = 2'b11; tick();
        tick();
        check("d3_load_next", {obs_en, obs_func, obs_stage}, {1'b1, 2'b00, 2'd3});
        check("d5_hp_kept", hp, 6'h3f);
        check("d5_stage_next", stage, 3);
        check("d5_wait", run, 0);

        // final stage cleared -> won
        start = 1; tick();
        n = 0;
        while (win !== 1'b1 && n < CELLS + 10) begin tick(); n++; end
        check("d3_win_bound", n < CELLS + 10, 1);
        check("d3_win", win, 1);

        // asynchronous reset in the middle of play
        do_reset();
        m_blank = 0;
        start = 1; tick();
        start = 1; tick();
        for (int k = 0; k < 7; k++) tick();
        do_reset();

        // random games
        for (int g = 0; g < 8; g++) begin
            do_reset();
            n = 0;
            while (m_st != M_LOST && m_st != M_WON && n < 3500) begin
                start      = ($urandom_range(7) == 0);
                pause      = ($urandom_range(99) == 0);
                ball_lost  = {($urandom_range(299) == 0), ($urandom_range(299) == 0)};
                ball_hit   = (m_st == M_PLAY && is_brk(m_map[m_t]) && $urandom_range(1) == 1) ?
                             2'($urandom_range(3, 1)) : 2'b00;
                give_ball  = ($urandom_range(399) == 0);
                drop_block = ($urandom_range(999) == 0);
                btn_l      = ($urandom_range(999) == 0);
                btn_r      = ($urandom_range(999) == 0);
                bm_ready   = ($urandom_range(1999) != 0);
                stage_ovr  = ($urandom_range(9) == 0);
                stage_sel  = 2'($urandom_range(3));
                tick();
                n++;
            end
            for (int k = 0; k < 5; k++) begin
                start = 1; ball_lost = 2'b11; tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
